pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Keeps an internal shadow pipeline of destination/control tags for the EX, MEM and WB stages.
- Generates registered forwarding selects for the EX-stage ALU operands, WB→ID register-file bypass, a load-use stall and branch-taken flushes.
- Sits beside the pipeline registers: drives their hold/flush inputs and the ALU operand muxes.

Parameters:
- REG_ADDR_W, 5, register address width; address 0 is hard-wired zero and is never forwarded.
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_ADDR_W  ID source register A
- id_rt  in  REG_ADDR_W  ID source register B
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_dest  in  REG_ADDR_W  ID destination, after the RegDest mux
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- branch_taken_mem  in  1  Branch_MEM & zeroALU_MEM
- stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  clear IF/ID
- flush_id_ex  out  1  load a bubble into ID/EX
- flush_ex_mem  out  1  load a bubble into EX/MEM
- fwd_a_sel  out  2  EX operand A source: 0 = ID/EX, 1 = EX/MEM ALU result, 2 = WB write data
- fwd_b_sel  out  2  same encoding, operand B
- wb_bypass_a  out  1  ID read A takes WB write data
- wb_bypass_b  out  1  ID read B takes WB write data
- stall_count  out  CNT_W  cycles stalled, saturating
- flush_count  out  CNT_W  branch flushes, saturating

Behaviour:
- Shadow entries ex/mem/wb, each = {valid, dest, regwrite, memread}. The shadow advances every cycle; there is no global freeze.
- Entry "writes R" ⇔ valid & regwrite & dest == R & R != 0.
- use_a ⇔ id_valid & id_uses_rs; use_b ⇔ id_valid & id_uses_rt.
- Load-use (combinational): load_use = ex.valid & ex.memread & ex writes (id_rs with use_a, or id_rt with use_b).
- Combinational outputs:
  - stall = load_use & ~branch_taken_mem.
  - flush_if_id = flush_ex_mem = branch_taken_mem.
  - flush_id_ex = branch_taken_mem | load_use.
- wb_bypass_a = use_a & wb writes id_rs; wb_bypass_b likewise for id_rt. Both combinational.
- Edge update:
  - ex <= bubble if flush_id_ex, else the ID tag.
  - mem <= bubble if branch_taken_mem, else ex.
  - wb <= mem.
- Registered selects: fwd_a_sel <= 1 if ex writes id_rs; else 2 if mem writes id_rs; else 0. Gated by use_a. The newer stage wins.
  - fwd_b_sel uses id_rt and use_b the same way.
  - Both are forced to 0 when flush_id_ex.
- Load-use stall is exactly 1 cycle. Next cycle the load is in MEM and the consumer gets sel = 2.
- Simultaneous branch_taken_mem and load_use: the flush wins.
  - stall = 0.
  - All three flushes = 1.
  - flush_count increments; stall_count does not.
- Counters:
  - stall_count increments on each stall cycle.
  - flush_count increments on each branch_taken_mem cycle.
  - Both saturate at all-ones; no wrap-around.
- Reset:
  - All shadow entries invalid.
  - fwd_a_sel = fwd_b_sel = 0; counters = 0.
  - Combinational outputs are then 0 unless branch_taken_mem is asserted.
  - Reset mid-stall discards the stall; the pipeline sees no hazard on the next cycle.
- Register 0: a dest of 0 never matches. No forwarding, stall or bypass occurs for r0.
- Select latency: a select is valid in the cycle its instruction is in EX, one clock after the ID evaluation.

Test Plan:
- R-type back-to-back: add r3 ← r1,r2 then sub r4 ← r3,r5 → next cycle fwd_a_sel = 1, fwd_b_sel = 0, stall never 1.
- Two-apart dependency: add r3, nop, or r6 ← r2,r3 → fwd_b_sel = 2 when the or is in EX; fwd_a_sel = 0.
- Load-use:
  - Stimulus: lw r8 then add r9 ← r8,r8.
  - Required: stall = 1 and flush_id_ex = 1 for exactly 1 cycle; stall_count = 1.
  - Required: next ID eval gives fwd_a_sel = fwd_b_sel = 2.
- Branch flush:
  - Stimulus: branch_taken_mem pulsed 1 cycle while lw r8 / add r8 hazard is present.
  - Required: stall = 0; flush_if_id, flush_id_ex and flush_ex_mem all 1.
  - Required: flush_count = 1; the following cycle shows ex and mem as bubbles (no forwarding).
- r0 and WB bypass:
  - Stimulus: add r0 ← …, then use r0 → selects 0, no stall.
  - Stimulus: WB writes r7 while ID reads r7 → wb_bypass_a = 1.
- Saturation/reset:
  - Stimulus: CNT_W = 2, force 5 stalls → stall_count = 3.
  - Stimulus: assert reset for 1 cycle → all outputs 0.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// A shadow pipeline of destination/control tags for EX, MEM and WB drives
// registered EX operand forwarding selects, a WB->ID register-file bypass,
// a one-cycle load-use stall and branch-taken flushes, plus saturating
// event counters. Register 0 is hard-wired zero and never matches.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  branch_taken_mem,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  wb_bypass_a,
  output logic                  wb_bypass_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // Forwarding select encoding for the EX operand muxes.
  localparam logic [1:0] SEL_IDEX  = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_WB    = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } tag_t;

  localparam tag_t BUBBLE = '0;

  tag_t ex_tag;
  tag_t mem_tag;
  tag_t wb_tag;
  tag_t id_tag;

  logic       use_a;
  logic       use_b;
  logic       load_use;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;

  // True when a shadow entry will write register r (r0 never counts).
  function automatic logic writes(input tag_t t, input logic [REG_ADDR_W-1:0] r);
    return t.valid && t.regwrite && (t.dest == r) && (r != '0);
  endfunction

  // Decode the ID instruction's operand usage, hazards and flushes.
  always_comb begin
    id_tag.valid    = id_valid;
    id_tag.dest     = id_dest;
    id_tag.regwrite = id_regwrite;
    id_tag.memread  = id_memread;

    use_a = id_valid && id_uses_rs;
    use_b = id_valid && id_uses_rt;

    // A load in EX cannot forward its data to an ID consumer in time.
    load_use = ex_tag.valid && ex_tag.memread &&
               ((use_a && writes(ex_tag, id_rs)) ||
                (use_b && writes(ex_tag, id_rt)));

    // A taken branch squashes the whole younger pipeline, so it overrides
    // the load-use stall (the consumer is being thrown away anyway).
    stall        = load_use && !branch_taken_mem;
    flush_if_id  = branch_taken_mem;
    flush_ex_mem = branch_taken_mem;
    flush_id_ex  = branch_taken_mem || load_use;

    wb_bypass_a = use_a && writes(wb_tag, id_rs);
    wb_bypass_b = use_b && writes(wb_tag, id_rt);
  end

  // Next forwarding selects for the instruction entering EX; newer stage wins.
  always_comb begin
    fwd_a_nxt = SEL_IDEX;
    fwd_b_nxt = SEL_IDEX;
    if (!flush_id_ex) begin
      if (use_a) begin
        if (writes(ex_tag, id_rs))       fwd_a_nxt = SEL_EXMEM;
        else if (writes(mem_tag, id_rs)) fwd_a_nxt = SEL_WB;
      end
      if (use_b) begin
        if (writes(ex_tag, id_rt))       fwd_b_nxt = SEL_EXMEM;
        else if (writes(mem_tag, id_rt)) fwd_b_nxt = SEL_WB;
      end
    end
  end

  // Advance the shadow pipeline and register the forwarding selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_tag    <= BUBBLE;
      mem_tag   <= BUBBLE;
      wb_tag    <= BUBBLE;
      fwd_a_sel <= SEL_IDEX;
      fwd_b_sel <= SEL_IDEX;
    end else begin
      ex_tag    <= flush_id_ex ? BUBBLE : id_tag;
      mem_tag   <= branch_taken_mem ? BUBBLE : ex_tag;
      wb_tag    <= mem_tag;
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
    end
  end

  // Saturating stall and branch-flush event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (branch_taken_mem && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed testbench for pipe_hazard_unit. Inputs change #1 after a rising
// edge; combinational outputs are sampled at the falling edge, registered
// outputs #1 after the rising edge. A second instance with 2-bit counters
// shares the inputs so counter saturation can be reached quickly.
module tb_pipe_hazard_unit;

  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic [AW-1:0] id_dest;
  logic          id_regwrite;
  logic          id_memread;
  logic          branch_taken_mem;

  logic          stall, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          wb_bypass_a, wb_bypass_b;
  logic [15:0]   stall_count, flush_count;

  logic          s_stall, s_flush_if_id, s_flush_id_ex, s_flush_ex_mem;
  logic [1:0]    s_fwd_a_sel, s_fwd_b_sel;
  logic          s_wb_bypass_a, s_wb_bypass_b;
  logic [1:0]    s_stall_count, s_flush_count;

  int n_cmp;
  int n_err;

  pipe_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken_mem(branch_taken_mem),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .wb_bypass_a(wb_bypass_a), .wb_bypass_b(wb_bypass_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipe_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken_mem(branch_taken_mem),
    .stall(s_stall), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
    .flush_ex_mem(s_flush_ex_mem), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .wb_bypass_a(s_wb_bypass_a), .wb_bypass_b(s_wb_bypass_b),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: all comparisons go through here
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic ur, input logic ut, input logic [AW-1:0] dest,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rs  = ur;
    id_uses_rt  = ut;
    id_dest     = dest;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic set_nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    set_nop();
    branch_taken_mem = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    branch_taken_mem = 1'b0;
    set_nop();
    do_reset();

    // Reset state
    settle();
    check("rst_stall", stall, 0);
    check("rst_flush_id_ex", flush_id_ex, 0);
    check("rst_fwd_a", fwd_a_sel, 0);
    check("rst_fwd_b", fwd_b_sel, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_flush_count", flush_count, 0);

    // R-type back-to-back: add r3<-r1,r2 ; sub r4<-r3,r5
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    settle();
    check("rr_stall0", stall, 0);
    tick();
    set_id(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0);
    settle();
    check("rr_stall1", stall, 0);
    tick();
    set_nop();
    check("rr_fwd_a", fwd_a_sel, 1);
    check("rr_fwd_b", fwd_b_sel, 0);

    // Two-apart: add r3 ; nop ; or r6<-r2,r3
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    tick();
    set_nop();
    tick();
    set_id(1, 5'd2, 5'd3, 1, 1, 5'd6, 1, 0);
    tick();
    set_nop();
    check("two_fwd_a", fwd_a_sel, 0);
    check("two_fwd_b", fwd_b_sel, 2);

    // Load-use: lw r8 ; add r9<-r8,r8
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
    tick();
    set_id(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0);
    settle();
    check("lu_stall", stall, 1);
    check("lu_flush_id_ex", flush_id_ex, 1);
    check("lu_flush_if_id", flush_if_id, 0);
    check("lu_flush_ex_mem", flush_ex_mem, 0);
    tick();
    check("lu_stall_count", stall_count, 1);
    check("lu_bubble_fwd_a", fwd_a_sel, 0);
    settle();
    check("lu_stall_once", stall, 0);
    check("lu_flush_once", flush_id_ex, 0);
    tick();
    set_nop();
    check("lu_fwd_a", fwd_a_sel, 2);
    check("lu_fwd_b", fwd_b_sel, 2);
    check("lu_stall_count_hold", stall_count, 1);

    // Branch flush coincident with a load-use hazard
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
    tick();
    set_id(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0);
    branch_taken_mem = 1'b1;
    settle();
    check("br_stall", stall, 0);
    check("br_flush_if_id", flush_if_id, 1);
    check("br_flush_id_ex", flush_id_ex, 1);
    check("br_flush_ex_mem", flush_ex_mem, 1);
    tick();
    branch_taken_mem = 1'b0;
    check("br_flush_count", flush_count, 1);
    check("br_stall_count", stall_count, 0);
    settle();
    check("br_after_stall", stall, 0);
    tick();
    set_nop();
    check("br_after_fwd_a", fwd_a_sel, 0);
    check("br_after_fwd_b", fwd_b_sel, 0);

    // r0 destination: lw r0 then a reader of r0
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 1);
    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0);
    settle();
    check("r0_stall", stall, 0);
    tick();
    set_nop();
    check("r0_fwd_a", fwd_a_sel, 0);
    check("r0_fwd_b", fwd_b_sel, 0);

    // WB bypass: add r7 reaches WB while ID reads r7
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0);
    tick();
    set_nop();
    tick();
    tick();
    set_id(1, 5'd7, 5'd3, 1, 1, 5'd10, 1, 0);
    settle();
    check("wb_bypass_a", wb_bypass_a, 1);
    check("wb_bypass_b", wb_bypass_b, 0);
    tick();
    set_nop();

    // Saturation: five load-use stalls
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
      tick();
      set_id(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0);
      settle();
      check("sat_stall", stall, 1);
      tick();
    end
    set_nop();
    check("sat_count16", stall_count, 5);
    check("sat_count2", s_stall_count, 3);

    // Reset in the middle of a stall
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
    tick();
    set_id(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0);
    settle();
    check("mid_stall", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("mid_rst_stall", stall, 0);
    check("mid_rst_flush_id_ex", flush_id_ex, 0);
    check("mid_rst_flush_if_id", flush_if_id, 0);
    check("mid_rst_bypass_a", wb_bypass_a, 0);
    check("mid_rst_fwd_a", fwd_a_sel, 0);
    check("mid_rst_fwd_b", fwd_b_sel, 0);
    check("mid_rst_stall_count", stall_count, 0);
    check("mid_rst_sat_count", s_stall_count, 0);
    check("mid_rst_flush_count", flush_count, 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
